change_dispenser: RTL and testbench
===================================

# change_dispenser

Downstream of the vending-machine controller: consumes its `change`/`finish` result and pays it out as a sequence of physical coins (10, 5, 1) to a coin ejector over a valid/ack handshake. Uses greedy decomposition, one coin per accepted handshake. A one-deep pending buffer absorbs a new result that arrives while a payout is still in progress. Reports the coin count and completion per transaction.

## Interface
- `WIDTH`, 6: width of `change` and of the internal remainder.
- `ACK_TIMEOUT`, 15: maximum cycles to wait for `coin_ack` (used only with `CHG_TIMEOUT_EN`).

- `clk` in 1: single clock, rising edge.
- `rst` in 1: one clock; reset is asynchronous and active-low.
- `finish` in 1: result strobe from the vending controller; sampled each rising edge.
- `change` in WIDTH: amount to pay; valid when `finish`=1.
- `coin_ack` in 1: ejector accepted the presented coin.
- `coin_valid` out 1: coin presented.
- `coin_type` out 2: 00 none, 01 one, 10 five, 11 ten.
- `coin_cnt` out 4: coins accepted in the current or last transaction.
- `busy` out 1: transaction in progress (state ≠ IDLE).
- `done` out 1: one-cycle pulse at transaction end.
- `overflow` out 1: sticky; a result was dropped.
- `err` out 1: sticky; ack timeout (tied 0 without the macro).

## Operation
- States:
  - IDLE: `busy`=0.
  - ISSUE: a coin is presented.
  - DONE: `done`=1 for exactly one cycle.
- IDLE + `finish`: load `change` into `rem` and clear `coin_cnt`. Go to DONE if `change`=0, else ISSUE.
- Coin selection, registered, computed from `rem` at load and after each ack:
  - `rem`≥10 → 11.
  - `rem`≥5 → 10.
  - Else → 01.
- ISSUE, `coin_valid`=1: hold `coin_type` stable until acked. On `coin_ack`:
  - `rem` -= denomination; `coin_cnt`++.
  - New remainder 0 → DONE (`coin_valid` 0, `coin_type` 00).
  - Else stay in ISSUE and present the next coin the following cycle.
- DONE:
  - Pending buffer full → load the pending value as a new transaction (DONE if 0, else ISSUE).
  - Else if `finish`=1 → load `change` directly.
  - Else → IDLE.
- `finish` while in ISSUE, or in DONE when the DONE-cycle load is taken from pending:
  - Pending empty → capture `change` into pending.
  - Pending full → drop the new value and set `overflow`.
- Pending consumed and refilled on the same edge is allowed. `finish` in DONE with pending full: pending moves to `rem` and `change` goes into pending.
- Decomposition is greedy. Maximum coins for WIDTH=6 is 10 (59 → 5×10, 1×5, 4×1), so `coin_cnt` never wraps.
- `coin_ack` without `coin_valid` is ignored.

## Timing
- Reset values: state IDLE, `rem` 0, pending empty, and all outputs 0 (`coin_valid`, `coin_type`, `coin_cnt`, `busy`, `done`, `overflow`, `err`).
- Reset is asynchronous and honoured mid-transaction. It clears everything: the coin in flight is abandoned with no `done`.
- Latency: `finish` sampled at edge N → `coin_valid`=1 and `busy`=1 from edge N.
- Coins are accepted at edges where `coin_valid` & `coin_ack`. With `coin_ack` held at 1, k coins take k cycles, then `done` is asserted on the next cycle.
- `change`=0: `done` pulses the cycle after `finish`, with `coin_cnt`=0.
- `coin_cnt` holds its final value until the next load.

## Configuration
- `CHG_TIMEOUT_EN` defined:
  - A cycle counter, reset on every ack and on entry to ISSUE, runs in ISSUE.
  - If `ACK_TIMEOUT` cycles elapse with no ack: drop `coin_valid`, discard `rem`, set `err` (sticky until reset), go to DONE.
  - Pending handling continues normally.
- Undefined: no counter; ISSUE waits indefinitely and `err` is constant 0.

## Test plan
- Reset low mid-ISSUE → all outputs 0 on the same edge; no `done`.
- `finish`, `change`=15, `coin_ack`=1 held → types 11, 10 on consecutive cycles; then `done`, `coin_cnt`=2.
- `change`=37, ack every third cycle → types 11,11,11,10,01,01, each stable until acked; `coin_cnt`=6.
- `change`=0 → `done` one cycle later, `coin_valid` never asserted, `coin_cnt`=0.
- `change`=16 with ack held low; `finish` with 3 then `finish` with 9 during ISSUE → 3 pending, 9 dropped, `overflow`=1. After 16 completes (10,5,1), 3 pays as 01,01,01.
- With `CHG_TIMEOUT_EN`: `change`=5, no ack → after 15 cycles `coin_valid`=0, `err`=1, `done` pulse, `coin_cnt`=0.

Source files
------------

// File: rtl/change_dispenser.sv
// rtl/change_dispenser.sv - greedy coin payout (10/5/1) over a valid/ack handshake
//
// Pays out each change/finish result from the vending controller as a sequence
// of coins. A one-deep pending buffer holds a result that arrives mid-payout.
// Optional build macro: CHG_TIMEOUT_EN enables the coin_ack timeout and err.
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-low reset
//   finish     in   result strobe; change is valid with it
//   change     in   amount to pay (WIDTH bits)
//   coin_ack   in   ejector accepted the presented coin
//   coin_valid out  coin presented
//   coin_type  out  00 none, 01 one, 10 five, 11 ten
//   coin_cnt   out  coins accepted in the current or last transaction
//   busy       out  transaction in progress
//   done       out  one-cycle pulse at transaction end
//   overflow   out  sticky: a result was dropped
//   err        out  sticky: ack timeout (constant 0 without CHG_TIMEOUT_EN)

module change_dispenser #(
    parameter int WIDTH       = 6,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             finish,
    input  logic [WIDTH-1:0] change,
    input  logic             coin_ack,
    output logic             coin_valid,
    output logic [1:0]       coin_type,
    output logic [3:0]       coin_cnt,
    output logic             busy,
    output logic             done,
    output logic             overflow,
    output logic             err
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [1:0]       coin_type_q, coin_type_d;
    logic [3:0]       coin_cnt_q, coin_cnt_d;
    logic             pend_full_q, pend_full_d;
    logic [WIDTH-1:0] pend_val_q, pend_val_d;
    logic             overflow_q, overflow_d;

    logic             load_en;
    logic [WIDTH-1:0] load_val;
    logic             capture_en;
    logic [WIDTH-1:0] rem_sub;

    function automatic logic [1:0] pick(input logic [WIDTH-1:0] r);
        if (r >= WIDTH'(10))     return 2'b11;
        else if (r >= WIDTH'(5)) return 2'b10;
        else                     return 2'b01;
    endfunction

    function automatic logic [WIDTH-1:0] denom(input logic [1:0] t);
        case (t)
            2'b11:   return WIDTH'(10);
            2'b10:   return WIDTH'(5);
            default: return WIDTH'(1);
        endcase
    endfunction

    assign rem_sub = rem_q - denom(coin_type_q);

`ifdef CHG_TIMEOUT_EN
    localparam int TW = $clog2(ACK_TIMEOUT + 1);
    logic [TW-1:0] timer_q, timer_d;
    logic          err_q, err_d;
`else
    logic unused_cfg;
    assign unused_cfg = (ACK_TIMEOUT != 0);
`endif

    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        coin_type_d = coin_type_q;
        coin_cnt_d  = coin_cnt_q;
        pend_full_d = pend_full_q;
        pend_val_d  = pend_val_q;
        overflow_d  = overflow_q;
        load_en     = 1'b0;
        load_val    = change;
        capture_en  = 1'b0;
`ifdef CHG_TIMEOUT_EN
        timer_d     = timer_q;
        err_d       = err_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (finish) begin
                    load_en  = 1'b1;
                    load_val = change;
                end
            end
            S_ISSUE: begin
                capture_en = finish;
                if (coin_ack) begin
                    coin_cnt_d = coin_cnt_q + 4'd1;
                    rem_d      = rem_sub;
                    if (rem_sub == '0) begin
                        state_d     = S_DONE;
                        coin_type_d = 2'b00;
                    end else begin
                        coin_type_d = pick(rem_sub);
                    end
`ifdef CHG_TIMEOUT_EN
                    timer_d = '0;
                end else if (timer_q == TW'(ACK_TIMEOUT - 1)) begin
                    // Ejector stalled: abandon the remainder and close out.
                    state_d     = S_DONE;
                    rem_d       = '0;
                    coin_type_d = 2'b00;
                    err_d       = 1'b1;
                end else begin
                    timer_d = timer_q + TW'(1);
`endif
                end
            end
            S_DONE: begin
                if (pend_full_q) begin
                    // Pending drains into rem; a finish on this same edge may refill it.
                    load_en     = 1'b1;
                    load_val    = pend_val_q;
                    pend_full_d = 1'b0;
                    capture_en  = finish;
                end else if (finish) begin
                    load_en  = 1'b1;
                    load_val = change;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (capture_en) begin
            if (!pend_full_d) begin
                pend_full_d = 1'b1;
                pend_val_d  = change;
            end else begin
                overflow_d = 1'b1;
            end
        end

        if (load_en) begin
            rem_d      = load_val;
            coin_cnt_d = 4'd0;
`ifdef CHG_TIMEOUT_EN
            timer_d    = '0;
`endif
            if (load_val == '0) begin
                state_d     = S_DONE;
                coin_type_d = 2'b00;
            end else begin
                state_d     = S_ISSUE;
                coin_type_d = pick(load_val);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            rem_q       <= '0;
            coin_type_q <= 2'b00;
            coin_cnt_q  <= 4'd0;
            pend_full_q <= 1'b0;
            pend_val_q  <= '0;
            overflow_q  <= 1'b0;
`ifdef CHG_TIMEOUT_EN
            timer_q     <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            coin_type_q <= coin_type_d;
            coin_cnt_q  <= coin_cnt_d;
            pend_full_q <= pend_full_d;
            pend_val_q  <= pend_val_d;
            overflow_q  <= overflow_d;
`ifdef CHG_TIMEOUT_EN
            timer_q     <= timer_d;
            err_q       <= err_d;
`endif
        end
    end

    assign coin_valid = (state_q == S_ISSUE);
    assign coin_type  = coin_type_q;
    assign coin_cnt   = coin_cnt_q;
    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_DONE);
    assign overflow   = overflow_q;
`ifdef CHG_TIMEOUT_EN
    assign err        = err_q;
`else
    assign err        = 1'b0;
`endif

endmodule

// File: tb/tb_change_dispenser.sv
// tb/tb_change_dispenser.sv - directed self-checking bench for change_dispenser

module tb_change_dispenser;

    logic       clk;
    logic       rst;
    logic       finish;
    logic [5:0] change;
    logic       coin_ack;
    logic       coin_valid;
    logic [1:0] coin_type;
    logic [3:0] coin_cnt;
    logic       busy;
    logic       done;
    logic       overflow;
    logic       err;

    int total  = 0;
    int passed = 0;

    change_dispenser #(.WIDTH(6), .ACK_TIMEOUT(15)) dut (
        .clk        (clk),
        .rst        (rst),
        .finish     (finish),
        .change     (change),
        .coin_ack   (coin_ack),
        .coin_valid (coin_valid),
        .coin_type  (coin_type),
        .coin_cnt   (coin_cnt),
        .busy       (busy),
        .done       (done),
        .overflow   (overflow),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // valid, type, cnt, busy, done in one call
    task automatic chk_out(input string tag, input logic v, input logic [1:0] t,
                           input logic [3:0] c, input logic b, input logic d);
        chk({tag, ".valid"}, 8'(coin_valid), 8'(v));
        chk({tag, ".type"},  8'(coin_type),  8'(t));
        chk({tag, ".cnt"},   8'(coin_cnt),   8'(c));
        chk({tag, ".busy"},  8'(busy),       8'(b));
        chk({tag, ".done"},  8'(done),       8'(d));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [1:0] exp37 [6];
    logic [1:0] exp59 [10];

    initial begin
        exp37 = '{2'b11, 2'b11, 2'b11, 2'b10, 2'b01, 2'b01};
        exp59 = '{2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b10, 2'b01, 2'b01, 2'b01, 2'b01};
        rst = 1'b0; finish = 1'b0; change = '0; coin_ack = 1'b0;
        step(); step();
        chk_out("reset", 1'b0, 2'b00, 4'd0, 1'b0, 1'b0);
        chk("reset.overflow", 8'(overflow), 8'd0);
        chk("reset.err", 8'(err), 8'd0);
        rst = 1'b1;
        step();

        // 15 with ack held: 10, 5, then done
        finish = 1'b1; change = 6'd15; coin_ack = 1'b1;
        step(); finish = 1'b0;
        chk_out("c15.load", 1'b1, 2'b11, 4'd0, 1'b1, 1'b0);
        step();
        chk_out("c15.second", 1'b1, 2'b10, 4'd1, 1'b1, 1'b0);
        step();
        chk_out("c15.done", 1'b0, 2'b00, 4'd2, 1'b1, 1'b1);
        coin_ack = 1'b0;
        step();
        chk_out("c15.idle", 1'b0, 2'b00, 4'd2, 1'b0, 1'b0);

        // stray ack while idle is ignored
        coin_ack = 1'b1;
        step();
        chk_out("stray_ack", 1'b0, 2'b00, 4'd2, 1'b0, 1'b0);
        coin_ack = 1'b0;

        // 37 with ack every third cycle
        finish = 1'b1; change = 6'd37;
        step(); finish = 1'b0;
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("c37.coin%0d.a", i), 8'(coin_type), 8'(exp37[i]));
            step();
            chk($sformatf("c37.coin%0d.b", i), 8'(coin_type), 8'(exp37[i]));
            chk($sformatf("c37.coin%0d.v", i), 8'(coin_valid), 8'd1);
            step();
            chk($sformatf("c37.coin%0d.c", i), 8'(coin_type), 8'(exp37[i]));
            coin_ack = 1'b1;
            step();
            coin_ack = 1'b0;
        end
        chk_out("c37.done", 1'b0, 2'b00, 4'd6, 1'b1, 1'b1);
        step();

        // zero change, then finish in DONE with pending empty loads directly
        finish = 1'b1; change = 6'd0;
        step();
        chk_out("c0.done", 1'b0, 2'b00, 4'd0, 1'b1, 1'b1);
        change = 6'd10;
        step(); finish = 1'b0;
        chk_out("c10.direct", 1'b1, 2'b11, 4'd0, 1'b1, 1'b0);
        coin_ack = 1'b1;
        step(); coin_ack = 1'b0;
        chk_out("c10.done", 1'b0, 2'b00, 4'd1, 1'b1, 1'b1);
        step();
        chk_out("c10.idle", 1'b0, 2'b00, 4'd1, 1'b0, 1'b0);

        // 16 with pending 3 and dropped 9
        finish = 1'b1; change = 6'd16;
        step();
        change = 6'd3;
        step();
        chk("pend.no_ovf", 8'(overflow), 8'd0);
        change = 6'd9;
        step(); finish = 1'b0;
        chk("pend.ovf", 8'(overflow), 8'd1);
        chk_out("c16.hold", 1'b1, 2'b11, 4'd0, 1'b1, 1'b0);
        coin_ack = 1'b1;
        step();
        chk_out("c16.five", 1'b1, 2'b10, 4'd1, 1'b1, 1'b0);
        step();
        chk_out("c16.one", 1'b1, 2'b01, 4'd2, 1'b1, 1'b0);
        step();
        chk_out("c16.done", 1'b0, 2'b00, 4'd3, 1'b1, 1'b1);
        step();
        chk_out("c3.load", 1'b1, 2'b01, 4'd0, 1'b1, 1'b0);
        step();
        chk_out("c3.two", 1'b1, 2'b01, 4'd1, 1'b1, 1'b0);
        step();
        chk_out("c3.three", 1'b1, 2'b01, 4'd2, 1'b1, 1'b0);
        step();
        chk_out("c3.done", 1'b0, 2'b00, 4'd3, 1'b1, 1'b1);
        coin_ack = 1'b0;
        step();
        chk_out("c3.idle", 1'b0, 2'b00, 4'd3, 1'b0, 1'b0);

        // pending consumed and refilled on the same DONE edge
        finish = 1'b1; change = 6'd1;
        step();
        change = 6'd2;
        step(); finish = 1'b0;
        coin_ack = 1'b1;
        step(); coin_ack = 1'b0;
        chk_out("refill.done1", 1'b0, 2'b00, 4'd1, 1'b1, 1'b1);
        finish = 1'b1; change = 6'd5;
        step(); finish = 1'b0;
        chk_out("refill.load2", 1'b1, 2'b01, 4'd0, 1'b1, 1'b0);
        coin_ack = 1'b1;
        step();
        chk_out("refill.c2b", 1'b1, 2'b01, 4'd1, 1'b1, 1'b0);
        step();
        chk_out("refill.done2", 1'b0, 2'b00, 4'd2, 1'b1, 1'b1);
        step();
        chk_out("refill.load5", 1'b1, 2'b10, 4'd0, 1'b1, 1'b0);
        step();
        chk_out("refill.done5", 1'b0, 2'b00, 4'd1, 1'b1, 1'b1);
        coin_ack = 1'b0;
        step();
        chk_out("refill.idle", 1'b0, 2'b00, 4'd1, 1'b0, 1'b0);

        // 59: maximum coin count
        finish = 1'b1; change = 6'd59; coin_ack = 1'b1;
        step(); finish = 1'b0;
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("c59.coin%0d", i), 8'(coin_type), 8'(exp59[i]));
            step();
        end
        chk_out("c59.done", 1'b0, 2'b00, 4'd10, 1'b1, 1'b1);
        coin_ack = 1'b0;
        step();

`ifdef CHG_TIMEOUT_EN
        // no ack: 15 cycles of coin_valid then timeout
        finish = 1'b1; change = 6'd5;
        step(); finish = 1'b0;
        for (int i = 0; i < 14; i++) step();
        chk_out("tmo.last", 1'b1, 2'b10, 4'd0, 1'b1, 1'b0);
        step();
        chk_out("tmo.done", 1'b0, 2'b00, 4'd0, 1'b1, 1'b1);
        chk("tmo.err", 8'(err), 8'd1);
        step();
`else
        chk("noto.err", 8'(err), 8'd0);
`endif

        // asynchronous reset mid-ISSUE
        finish = 1'b1; change = 6'd16;
        step(); finish = 1'b0;
        chk_out("rst.pre", 1'b1, 2'b11, 4'd0, 1'b1, 1'b0);
        #2 rst = 1'b0;
        #1;
        chk_out("rst.async", 1'b0, 2'b00, 4'd0, 1'b0, 1'b0);
        chk("rst.overflow", 8'(overflow), 8'd0);
        chk("rst.err", 8'(err), 8'd0);
        step();
        chk_out("rst.held", 1'b0, 2'b00, 4'd0, 1'b0, 1'b0);
        rst = 1'b1;
        step();
        chk_out("rst.after", 1'b0, 2'b00, 4'd0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
